// File: rtl/demux_frame_if.sv
// Bus bundle for demux_frame: word input stream plus channel/status outputs.
// DEMUX_PARITY_EN adds the in_par / par_err pair.
interface demux_frame_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             sel_mode;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             frame_valid;
    logic [1:0]       ptr;
    logic [3:0]       filled;
    logic             overrun;
`ifdef DEMUX_PARITY_EN
    logic             in_par;
    logic             par_err;

    modport master (
        output in_data, in_valid, sel_mode, in_sel, in_par,
        input  A, B, C, D, frame_valid, ptr, filled, overrun, par_err
    );
    modport slave (
        input  in_data, in_valid, sel_mode, in_sel, in_par,
        output A, B, C, D, frame_valid, ptr, filled, overrun, par_err
    );
`else
    modport master (
        output in_data, in_valid, sel_mode, in_sel,
        input  A, B, C, D, frame_valid, ptr, filled, overrun
    );
    modport slave (
        input  in_data, in_valid, sel_mode, in_sel,
        output A, B, C, D, frame_valid, ptr, filled, overrun
    );
`endif
endinterface

// File: rtl/demux_frame.sv
// 1-to-4 registered demultiplexer with a shadow bank; A..D update atomically per frame.
// Optional macro DEMUX_PARITY_EN: drop words whose in_par disagrees with ^in_data.
module demux_frame #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          reset,
    demux_frame_if.slave bus
);
    logic [WIDTH-1:0] shadow     [4];
    logic [WIDTH-1:0] out_q      [4];
    logic [WIDTH-1:0] frame_next [4];
    logic [3:0]       filled_q;
    logic [3:0]       base_filled;
    logic [3:0]       onehot;
    logic [1:0]       ptr_q;
    logic [1:0]       base_ptr;
    logic [1:0]       slot;
    logic             prev_mode;
    logic             mode_change;
    logic             accept;
    logic             hit;
    logic             complete;
    logic             frame_valid_q;
    logic             overrun_q;
`ifdef DEMUX_PARITY_EN
    logic             par_ok;
    logic             par_err_q;
`endif

    // A mode switch discards the partial frame before the current word is considered,
    // so a word in that cycle lands as the first word of a fresh frame.
    always_comb begin
        mode_change = (bus.sel_mode != prev_mode);
        base_filled = mode_change ? 4'b0000 : filled_q;
        base_ptr    = mode_change ? 2'd0 : ptr_q;
        slot        = bus.sel_mode ? bus.in_sel : base_ptr;
        onehot      = 4'b0001 << slot;
        hit         = base_filled[slot];
`ifdef DEMUX_PARITY_EN
        par_ok      = (bus.in_par == ^bus.in_data);
        accept      = bus.in_valid && par_ok;
`else
        accept      = bus.in_valid;
`endif
        complete    = accept && !hit && ((base_filled | onehot) == 4'b1111);
        for (int i = 0; i < 4; i++) begin
            frame_next[i] = (slot == i[1:0]) ? bus.in_data : shadow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                out_q[i]  <= '0;
            end
            filled_q      <= 4'b0000;
            ptr_q         <= 2'd0;
            prev_mode     <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_err_q     <= 1'b0;
`endif
        end else begin
            prev_mode     <= bus.sel_mode;
            frame_valid_q <= complete;
            overrun_q     <= accept && hit;
`ifdef DEMUX_PARITY_EN
            par_err_q     <= bus.in_valid && !par_ok;
`endif
            filled_q      <= base_filled;
            ptr_q         <= base_ptr;
            if (accept) begin
                shadow[slot] <= bus.in_data;
                if (complete) begin
                    for (int i = 0; i < 4; i++) begin
                        out_q[i] <= frame_next[i];
                    end
                    filled_q <= 4'b0000;
                    ptr_q    <= 2'd0;
                end else if (!hit) begin
                    filled_q <= base_filled | onehot;
                    if (!bus.sel_mode) begin
                        ptr_q <= base_ptr + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.A           = out_q[0];
    assign bus.B           = out_q[1];
    assign bus.C           = out_q[2];
    assign bus.D           = out_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.ptr         = ptr_q;
    assign bus.filled      = filled_q;
`ifdef DEMUX_PARITY_EN
    assign bus.par_err     = par_err_q;
`endif
endmodule

// File: tb/tb_demux_frame.sv
// Self-checking bench for demux_frame: directed scenarios plus a randomized run
// against a frame-level reference model.
module tb_demux_frame;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    demux_frame_if #(.WIDTH(4)) bus ();

    demux_frame #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a set of written slots; outputs show the last full set.
    logic [3:0] m_shadow [4];
    logic [3:0] m_out    [4];
    int         m_filled;
    int         m_ptr;
    bit         m_mode;
    bit         m_fv;
    bit         m_ovr;
    bit         m_perr;

    task automatic model_edge(input bit rst, input bit valid, input bit mode,
                              input logic [1:0] sel, input logic [3:0] data, input bit par);
        int s;
        bit ok;
        m_fv   = 0;
        m_ovr  = 0;
        m_perr = 0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 4'h0;
                m_out[i]    = 4'h0;
            end
            m_filled = 0;
            m_ptr    = 0;
            m_mode   = 0;
            return;
        end
        if (mode != m_mode) begin
            m_filled = 0;
            m_ptr    = 0;
        end
        m_mode = mode;
`ifdef DEMUX_PARITY_EN
        ok = (par == ^data);
        if (valid && !ok) m_perr = 1;
`else
        ok = 1;
`endif
        if (!(valid && ok)) return;
        s = mode ? int'(sel) : m_ptr;
        m_shadow[s] = data;
        if ((m_filled >> s) % 2 == 1) begin
            m_ovr = 1;
            return;
        end
        m_filled = m_filled + (1 << s);
        if (!mode) m_ptr = (m_ptr + 1) % 4;
        if (m_filled == 15) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
            m_fv     = 1;
            m_filled = 0;
            m_ptr    = 0;
        end
    endtask

    task automatic drive(input bit rst, input bit valid, input bit mode,
                         input logic [1:0] sel, input logic [3:0] data, input bit par);
        reset        = rst;
        bus.in_valid = valid;
        bus.sel_mode = mode;
        bus.in_sel   = sel;
        bus.in_data  = data;
`ifdef DEMUX_PARITY_EN
        bus.in_par   = par;
`endif
        @(posedge clk);
        model_edge(rst, valid, mode, sel, data, par);
        #1;
    endtask

    task automatic word(input bit mode, input logic [1:0] sel, input logic [3:0] data);
        drive(0, 1, mode, sel, data, ^data);
    endtask

    function automatic logic [24:0] obs_vec();
        logic pe;
`ifdef DEMUX_PARITY_EN
        pe = bus.par_err;
`else
        pe = 1'b0;
`endif
        return {bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.overrun, bus.ptr, bus.filled, pe};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_ovr,
                m_ptr[1:0], m_filled[3:0], m_perr};
    endfunction

    task automatic test_reset();
        drive(1, 1, 0, 2'd0, 4'hF, 1);
        drive(1, 0, 0, 2'd0, 4'h0, 0);
        n_cmp++;
        if (obs_vec() !== 25'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(), 25'h0);
        end
    endtask

    task automatic test_auto_fill();
        for (int i = 1; i <= 4; i++) begin
            word(0, 2'd0, 4'(i));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL auto_fill_%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.filled, bus.ptr} !== {16'h1234, 1'b1, 4'b0000, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL auto_frame: got %h%h%h%h fv=%b filled=%b ptr=%0d expected 1234 fv=1 filled=0000 ptr=0",
                     bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.filled, bus.ptr);
        end
        drive(0, 0, 0, 2'd0, 4'h0, 0);
        n_cmp++;
        if (bus.frame_valid !== 1'b0 || bus.A !== 4'h1) begin
            n_fail++;
            $display("[TB] FAIL auto_fv_pulse: got fv=%b A=%h expected fv=0 A=1", bus.frame_valid, bus.A);
        end
    endtask

    task automatic test_explicit();
        logic [1:0] sels [4];
        logic [3:0] dats [4];
        sels = '{2'd3, 2'd0, 2'd2, 2'd1};
        dats = '{4'h9, 4'h5, 4'h7, 4'hE};
        drive(1, 0, 1, 2'd0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            word(1, sels[i], dats[i]);
            n_cmp++;
            if (i < 3 && {bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== 17'h0) begin
                n_fail++;
                $display("[TB] FAIL explicit_hold_%0d: got %h%h%h%h fv=%b expected 0000 fv=0",
                         i, bus.A, bus.B, bus.C, bus.D, bus.frame_valid);
            end else if (i == 3 && {bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== {16'h5E79, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL explicit_frame: got %h%h%h%h fv=%b expected 5E79 fv=1",
                         bus.A, bus.B, bus.C, bus.D, bus.frame_valid);
            end
        end
    endtask

    task automatic test_overrun();
        word(1, 2'd0, 4'h3);
        word(1, 2'd0, 4'h6);
        n_cmp++;
        if (bus.overrun !== 1'b1 || bus.filled !== 4'b0001 || bus.frame_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_pulse: got ovr=%b filled=%b fv=%b expected ovr=1 filled=0001 fv=0",
                     bus.overrun, bus.filled, bus.frame_valid);
        end
        word(1, 2'd1, 4'h1);
        n_cmp++;
        if (bus.overrun !== 1'b0 || bus.filled !== 4'b0011) begin
            n_fail++;
            $display("[TB] FAIL overrun_clear: got ovr=%b filled=%b expected ovr=0 filled=0011",
                     bus.overrun, bus.filled);
        end
        word(1, 2'd2, 4'h2);
        word(1, 2'd3, 4'h8);
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== {16'h6128, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL overrun_frame: got %h%h%h%h fv=%b expected 6128 fv=1",
                     bus.A, bus.B, bus.C, bus.D, bus.frame_valid);
        end
    endtask

    task automatic test_abort();
        word(0, 2'd0, 4'h1);
        word(0, 2'd0, 4'h2);
        n_cmp++;
        if (bus.filled !== 4'b0011 || bus.ptr !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL abort_pre: got filled=%b ptr=%0d expected filled=0011 ptr=2", bus.filled, bus.ptr);
        end
        drive(0, 0, 1, 2'd0, 4'h0, 0);
        n_cmp++;
        if ({bus.filled, bus.ptr, bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== {4'b0000, 2'd0, 16'h6128, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL abort: got filled=%b ptr=%0d out=%h%h%h%h fv=%b expected filled=0000 ptr=0 out=6128 fv=0",
                     bus.filled, bus.ptr, bus.A, bus.B, bus.C, bus.D, bus.frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) word(0, 2'd0, 4'hA + 4'(i));
        drive(1, 1, 0, 2'd0, 4'hD, ^4'hD);
        n_cmp++;
        if (obs_vec() !== 25'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got %h expected %h", obs_vec(), 25'h0);
        end
        for (int i = 0; i < 4; i++) word(0, 2'd0, 4'h4 - 4'(i));
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.ptr} !== {16'h4321, 1'b1, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_frame: got %h%h%h%h fv=%b ptr=%0d expected 4321 fv=1 ptr=0",
                     bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.ptr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            word(0, 2'd0, 4'(i + 7));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL back_to_back_%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity();
        drive(1, 0, 0, 2'd0, 4'h0, 0);
        drive(0, 1, 0, 2'd0, 4'h3, 1);
        n_cmp++;
        if (bus.par_err !== 1'b1 || bus.ptr !== 2'd0 || bus.filled !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL parity_drop: got perr=%b ptr=%0d filled=%b expected perr=1 ptr=0 filled=0000",
                     bus.par_err, bus.ptr, bus.filled);
        end
        drive(0, 1, 0, 2'd0, 4'h3, 0);
        n_cmp++;
        if (bus.par_err !== 1'b0 || bus.ptr !== 2'd1 || bus.filled !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL parity_accept: got perr=%b ptr=%0d filled=%b expected perr=0 ptr=1 filled=0001",
                     bus.par_err, bus.ptr, bus.filled);
        end
        for (int i = 0; i < 3; i++) word(0, 2'd0, 4'h5);
        n_cmp++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== {16'h3555, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL parity_frame: got %h%h%h%h fv=%b expected 3555 fv=1",
                     bus.A, bus.B, bus.C, bus.D, bus.frame_valid);
        end
    endtask
`endif

    task automatic test_random();
        bit         mode = 0;
        bit         rst;
        bit         valid;
        bit         par;
        logic [1:0] sel;
        logic [3:0] data;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            valid = ($urandom_range(0, 3) != 0);
            sel   = 2'($urandom_range(0, 3));
            data  = 4'($urandom_range(0, 15));
            par   = ^data;
            if ($urandom_range(0, 7) == 0) par = ~par;
            drive(rst, valid, mode, sel, data, par);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.sel_mode = 1'b0;
        bus.in_sel   = 2'd0;
        bus.in_data  = 4'h0;
`ifdef DEMUX_PARITY_EN
        bus.in_par   = 1'b0;
`endif
        $display("[TB] starting demux_frame bench");
        test_reset();
        test_auto_fill();
        test_explicit();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
